// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: arbitrates entry/exit0/exit1 gates onto one occupancy datapath.
// Define PARKING_EXIT_PRIORITY_EN for fixed exit0 > exit1 > entry priority instead of round-robin.
module parking_gate_arbiter #(
    parameter int FLOOR_CAP   = 500,
    parameter int OPEN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req_i,
    input  logic       exit0_req_i,
    input  logic       exit1_req_i,
    output logic       entry_ack_o,
    output logic       exit0_ack_o,
    output logic       exit1_ack_o,
    output logic       deny_o,
    output logic [2:0] grant_o,
    output logic       gate_open_o,
    output logic [9:0] cars_o,
    output logic [9:0] available_o,
    output logic       floor0_o,
    output logic       floor1_o,
    output logic       full_o
);
    localparam int CW = $clog2(OPEN_CYCLES + 1);
    localparam logic [8:0] CAP = 9'(FLOOR_CAP);
    localparam logic [9:0] LOT = 10'(2 * FLOOR_CAP);

    typedef enum logic [2:0] {IDLE, GRANT, OPEN, COMMIT, REFUSE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    req, cand, win_d, armed_q, ack_q;
    logic [8:0]    f0_q, f1_q, f0_d, f1_d;
    logic          valid_d;

    function automatic logic [2:0] pick(input logic [2:0] c, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        return c[a] ? 3'b001 << a : c[b] ? 3'b001 << b : c[d] ? 3'b001 << d : 3'b000;
    endfunction

    assign req  = {exit1_req_i, exit0_req_i, entry_req_i};
    assign cand = req & armed_q;

`ifdef PARKING_EXIT_PRIORITY_EN
    assign win_d = pick(cand, 2'd1, 2'd2, 2'd0);
`else
    logic [1:0] ptr_q;
    // ptr_q is the requester searched first; it moves past each winner, refused ones included
    assign win_d = ptr_q == 2'd0 ? pick(cand, 2'd0, 2'd1, 2'd2) :
                   ptr_q == 2'd1 ? pick(cand, 2'd1, 2'd2, 2'd0) : pick(cand, 2'd2, 2'd0, 2'd1);
`endif

    assign cars_o      = 10'(f0_q) + 10'(f1_q);
    assign available_o = LOT - cars_o;
    assign {exit1_ack_o, exit0_ack_o, entry_ack_o} = ack_q;

    always_comb begin
        valid_d = grant_o[0] ? cars_o != LOT : grant_o[1] ? f0_q != '0 : f1_q != '0;
        f0_d    = f0_q + 9'(grant_o[0] && f0_q < CAP) - 9'(grant_o[1]);
        f1_d    = f1_q + 9'(grant_o[0] && f0_q >= CAP) - 9'(grant_o[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_o     <= '0;
            gate_open_o <= 1'b0;
            ack_q       <= '0;
            deny_o      <= 1'b0;
            armed_q     <= '1;
            f0_q        <= '0;
            f1_q        <= '0;
            floor0_o    <= 1'b1;
            floor1_o    <= 1'b0;
            full_o      <= 1'b0;
`ifndef PARKING_EXIT_PRIORITY_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            ack_q   <= '0;
            deny_o  <= 1'b0;
            armed_q <= armed_q | ~req;
            case (state_q)
                IDLE: begin
                    if (|win_d) begin
                        grant_o <= win_d;
                        state_q <= GRANT;
`ifndef PARKING_EXIT_PRIORITY_EN
                        ptr_q   <= win_d[0] ? 2'd1 : win_d[1] ? 2'd2 : 2'd0;
`endif
                    end
                end
                GRANT: begin
                    if (valid_d) begin
                        state_q     <= OPEN;
                        gate_open_o <= 1'b1;
                        cnt_q       <= CW'(OPEN_CYCLES - 1);
                    end else begin
                        state_q <= REFUSE;
                        deny_o  <= 1'b1;
                        ack_q   <= grant_o;
                        grant_o <= '0;
                        armed_q <= (armed_q | ~req) & ~grant_o;
                    end
                end
                OPEN: begin
                    if (cnt_q == '0) begin
                        state_q     <= COMMIT;
                        gate_open_o <= 1'b0;
                        ack_q       <= grant_o;
                        grant_o     <= '0;
                        armed_q     <= (armed_q | ~req) & ~grant_o;
                        f0_q        <= f0_d;
                        f1_q        <= f1_d;
                        floor0_o    <= f0_d < CAP;
                        floor1_o    <= f0_d >= CAP && f1_d < CAP;
                        full_o      <= f0_d == CAP && f1_d == CAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: randomized transaction-level check against a lot occupancy model.
module tb_parking_gate_arbiter;
    localparam int CAP = 500;
    localparam int OC  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = '0;
    logic       entry_ack, exit0_ack, exit1_ack, deny, gate_open, floor0, floor1, full;
    logic [2:0] grant, ack;
    logic [9:0] cars, available;

    int       n_chk = 0;
    int       n_pass = 0;
    int       f0, f1, ptr;
    bit [2:0] armed;

    parking_gate_arbiter #(.FLOOR_CAP(CAP), .OPEN_CYCLES(OC)) dut (
        .clk(clk), .rst(rst),
        .entry_req_i(req[0]), .exit0_req_i(req[1]), .exit1_req_i(req[2]),
        .entry_ack_o(entry_ack), .exit0_ack_o(exit0_ack), .exit1_ack_o(exit1_ack),
        .deny_o(deny), .grant_o(grant), .gate_open_o(gate_open),
        .cars_o(cars), .available_o(available),
        .floor0_o(floor0), .floor1_o(floor1), .full_o(full)
    );

    assign ack = {exit1_ack, exit0_ack, entry_ack};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cars"}, 32'(cars), 32'(f0 + f1));
        check({tag, "_avail"}, 32'(available), 32'(2 * CAP - f0 - f1));
        check({tag, "_ind"}, 32'({full, floor1, floor0}), 32'({f0 == CAP && f1 == CAP, f0 >= CAP && f1 < CAP, f0 < CAP}));
    endtask

    task automatic tick();
        armed |= ~req;
        @(posedge clk);
        #1;
    endtask

    task automatic arb(input logic [2:0] raise, input bit keep, input bit rnd);
        logic [2:0] cand;
        int w, opened, bad;
        bit ok;
        req |= raise;
        cand = req & armed;
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
`ifdef PARKING_EXIT_PRIORITY_EN
            i = (k + 1) % 3;
`else
            i = (ptr + k) % 3;
`endif
            if (w < 0 && cand[i]) w = i;
        end
        tick();
        if (w < 0) begin
            check("idle_grant", 32'(grant), 0);
            return;
        end
        ptr = (w + 1) % 3;
        check("grant", 32'(grant), 32'(1) << w);
        check("grant_gate", 32'(gate_open), 0);
        ok = w == 0 ? f0 + f1 < 2 * CAP : w == 1 ? f0 > 0 : f1 > 0;
        tick();
        if (!ok) begin
            armed[w] = 1'b0;
            check("deny", 32'(deny), 1);
            check("refuse_ack", 32'(ack), 32'(1) << w);
            check("refuse_gate", 32'(gate_open), 0);
            check_status("refuse");
        end else begin
            opened = 0;
            bad = 0;
            for (int k = 0; k < OC; k++) begin
                opened += int'(gate_open);
                if (ack != 0 || deny || cars != 10'(f0 + f1)) bad++;
                if (rnd) begin
                    for (int i = 0; i < 3; i++)
                        if (i != w && !req[i] && $urandom % 4 == 0) req[i] = 1'b1;
                    if ($urandom % 16 == 0) req[w] = 1'b0;
                end
                tick();
            end
            armed[w] = 1'b0;
            if (w == 0) begin
                if (f0 < CAP) f0++;
                else f1++;
            end else if (w == 1) f0--;
            else f1--;
            check("open_len", 32'(opened), 32'(OC));
            check("open_quiet", 32'(bad), 0);
            check("commit_ack", 32'(ack), 32'(1) << w);
            check("commit_deny", 32'(deny), 0);
            check("commit_gate", 32'(gate_open), 0);
            check_status("commit");
        end
        if (!keep) req[w] = 1'b0;
        tick();
        check("ack_pulse", 32'({ack, deny}), 0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        f0 = 0;
        f1 = 0;
        ptr = 0;
        armed = '1;
        check("rst_grant", 32'(grant), 0);
        check("rst_gate", 32'(gate_open), 0);
        check("rst_ack", 32'({ack, deny}), 0);
        check_status("rst");
        rst = 1'b0;

        arb(3'b001, 1'b0, 1'b0);
        arb(3'b100, 1'b0, 1'b0);
        while (f0 + f1 < CAP) arb(3'b001, 1'b0, 1'b0);
        arb(3'b010, 1'b0, 1'b0);
        while (f0 + f1 < 2 * CAP) arb(3'b001, 1'b0, 1'b0);
        arb(3'b001, 1'b0, 1'b0);
        arb(3'b001, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom % 3 == 0) req &= 3'($urandom);
            arb(3'($urandom_range(0, 7)), $urandom % 4 == 0, 1'b1);
        end

        req = '0;
        tick();
        tick();
        req = f0 > 0 ? 3'b010 : f1 > 0 ? 3'b100 : 3'b001;
        tick();
        tick();
        tick();
        check("open_before_rst", 32'(gate_open), 1);
        #2 rst = 1'b1;
        #1;
        f0 = 0;
        f1 = 0;
        check("rst_mid_gate", 32'(gate_open), 0);
        check("rst_mid_grant", 32'(grant), 0);
        check_status("rst_mid");
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        ptr = 0;
        armed = '1;

        repeat (5) arb(3'b001, 1'b0, 1'b0);
        arb(3'b100, 1'b0, 1'b0);
        repeat (5) arb(3'b111, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
